// File: rtl/pll_rst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pll_rst_ctrl
// Summary  : PLL reset sequencer; re-arms the PLL on timeout/lock loss and
//            releases the system reset only after lock has been stable.
// Revision : 1.0
// ============================================================================
module pll_rst_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYS_HOLD_CYCLES     = 64
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pll_locked_i,
  input  logic       sys_rst_req_i,
  output logic       pll_rst_o,
  output logic       sys_rstn_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int c_max_ab  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int c_max_cd  = (LOCK_STABLE_CYCLES > SYS_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : SYS_HOLD_CYCLES;
  localparam int c_max_cyc = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w   = $clog2(c_max_cyc) + 1;

  localparam logic [2:0] c_st_pll_rst   = 3'd0;
  localparam logic [2:0] c_st_wait_lock = 3'd1;
  localparam logic [2:0] c_st_stable    = 3'd2;
  localparam logic [2:0] c_st_run       = 3'd3;
  localparam logic [2:0] c_st_hold      = 3'd4;

  localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(SYS_HOLD_CYCLES - 1);
  // The WAIT_LOCK->STABLE edge already counts as stable cycle 1.
  localparam logic [c_cnt_w-1:0] c_stable_last  =
    c_cnt_w'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam logic [2:0] c_st_after_lock =
    (LOCK_STABLE_CYCLES == 1) ? c_st_run : c_st_stable;

  logic               r_lock_meta;
  logic               r_lock_s;
  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pll_rst;
  logic               r_sys_rstn;
  logic               r_lock_lost;
  logic [7:0]         r_retry;

  logic [2:0]         w_state_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_cnt_restart;
  logic               w_retry_inc;
  logic               w_set_lost;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_restart = 1'b0;
    w_retry_inc   = 1'b0;
    w_set_lost    = 1'b0;
    case (r_state)
      c_st_pll_rst: begin
        if (r_cnt == c_rst_last) w_state_nxt = c_st_wait_lock;
      end
      c_st_wait_lock: begin
        if (r_lock_s) begin
          w_state_nxt = c_st_after_lock;
        end else if (r_cnt == c_timeout_last) begin
          w_state_nxt = c_st_pll_rst;
          w_retry_inc = 1'b1;
        end
      end
      c_st_stable: begin
        if (!r_lock_s)                   w_state_nxt = c_st_wait_lock;
        else if (r_cnt == c_stable_last) w_state_nxt = c_st_run;
      end
      c_st_run: begin
        if (!r_lock_s) begin
          w_state_nxt = c_st_pll_rst;
          w_set_lost  = 1'b1;
          w_retry_inc = 1'b1;
        end else if (sys_rst_req_i) begin
          w_state_nxt = c_st_hold;
        end
      end
      c_st_hold: begin
        if (!r_lock_s) begin
          w_state_nxt = c_st_pll_rst;
          w_set_lost  = 1'b1;
          w_retry_inc = 1'b1;
        end else if (sys_rst_req_i) begin
          // Hold time is measured from the cycle the request goes away.
          w_cnt_restart = 1'b1;
        end else if (r_cnt == c_hold_last) begin
          w_state_nxt = c_st_run;
        end
      end
      default: w_state_nxt = c_st_pll_rst;
    endcase

    if ((w_state_nxt != r_state) || w_cnt_restart || (r_state == c_st_run))
      w_cnt_nxt = '0;
    else
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= c_st_pll_rst;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rstn  <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry     <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pll_rst  <= (w_state_nxt == c_st_pll_rst);
      r_sys_rstn <= (w_state_nxt == c_st_run);
      if (w_set_lost)
        r_lock_lost <= 1'b1;
      if (w_retry_inc && (r_retry != 8'hFF))
        r_retry <= r_retry + 8'd1;
    end
  end

  assign pll_rst_o   = r_pll_rst;
  assign sys_rstn_o  = r_sys_rstn;
  assign lock_lost_o = r_lock_lost;
  assign retry_cnt_o = r_retry;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pll_rst_ctrl
// Summary  : Directed self-checking bench for pll_rst_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sys_rst_req = 1'b0;
  logic       pll_rst, sys_rstn, lock_lost;
  logic [7:0] retry;
  logic [2:0] state;

  logic       rstn2 = 1'b0;
  logic       locked2 = 1'b0;
  logic       req2 = 1'b0;
  logic       pll_rst2, sys_rstn2, lock_lost2;
  logic [7:0] retry2;
  logic [2:0] state2;

  int n_pass  = 0;
  int n_total = 0;

  logic model_en   = 1'b1;
  logic model_drop = 1'b0;
  int   pll_cnt    = 0;

  always #5 clk = ~clk;

  pll_rst_ctrl #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8), .SYS_HOLD_CYCLES(5)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .pll_locked_i(pll_locked),
    .sys_rst_req_i(sys_rst_req), .pll_rst_o(pll_rst), .sys_rstn_o(sys_rstn),
    .lock_lost_o(lock_lost), .retry_cnt_o(retry), .state_o(state)
  );

  pll_rst_ctrl #(
    .PLL_RST_CYCLES(1), .LOCK_TIMEOUT_CYCLES(2),
    .LOCK_STABLE_CYCLES(2), .SYS_HOLD_CYCLES(1)
  ) dut_sat (
    .clk_i(clk), .rstn_i(rstn2), .pll_locked_i(locked2),
    .sys_rst_req_i(req2), .pll_rst_o(pll_rst2), .sys_rstn_o(sys_rstn2),
    .lock_lost_o(lock_lost2), .retry_cnt_o(retry2), .state_o(state2)
  );

  // PLL model: locks 10 cycles after its reset falls, unless disabled/dropped.
  always @(negedge clk) begin
    if (pll_rst) pll_cnt = 0;
    else if (pll_cnt < 100) pll_cnt = pll_cnt + 1;
    pll_locked = model_en && !model_drop && !pll_rst && (pll_cnt >= 10);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from the first edge sampling locked=1 to the edge raising sys_rstn.
  task automatic measure_release(output int n);
    n = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (pll_locked === 1'b1) break;
    end
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (sys_rstn === 1'b1) begin
        n = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_total++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst); else n_pass++;
    n_total++; if (sys_rstn !== 1'b0) $display("FAIL reset_sys_rstn: got %b want 0", sys_rstn); else n_pass++;
    n_total++; if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost: got %b want 0", lock_lost); else n_pass++;
    n_total++; if (retry !== 8'd0) $display("FAIL reset_retry: got %0d want 0", retry); else n_pass++;
    n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_powerup();
    int n;
    rstn = 1'b1;
    tick(); tick(); tick();
    n_total++; if (pll_rst !== 1'b1) $display("FAIL pwr_pll_rst_edge3: got %b want 1", pll_rst); else n_pass++;
    tick();
    n_total++; if (pll_rst !== 1'b0) $display("FAIL pwr_pll_rst_edge4: got %b want 0", pll_rst); else n_pass++;
    n_total++; if (state !== 3'd1) $display("FAIL pwr_wait_lock: got %0d want 1", state); else n_pass++;
    measure_release(n);
    n_total++; if (n !== 9) $display("FAIL pwr_release_latency: got %0d want 9", n); else n_pass++;
    n_total++; if (state !== 3'd3) $display("FAIL pwr_state_run: got %0d want 3", state); else n_pass++;
    n_total++; if (retry !== 8'd0) $display("FAIL pwr_retry: got %0d want 0", retry); else n_pass++;
    n_total++; if (lock_lost !== 1'b0) $display("FAIL pwr_lock_lost: got %b want 0", lock_lost); else n_pass++;
  endtask

  task automatic test_sw_reset();
    int n;
    int bad_pll;
    bad_pll = 0;
    sys_rst_req = 1'b1;
    tick();
    n_total++; if (sys_rstn !== 1'b0) $display("FAIL sw_immediate_drop: got %b want 0", sys_rstn); else n_pass++;
    sys_rst_req = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_rst !== 1'b0) bad_pll++;
      if (sys_rstn === 1'b1) break;
      n++;
    end
    n_total++; if (n !== 5) $display("FAIL sw_pulse_low_cycles: got %0d want 5", n); else n_pass++;

    sys_rst_req = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      if (sys_rstn !== 1'b0) bad_pll++;
      if (pll_rst !== 1'b0) bad_pll++;
    end
    sys_rst_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (pll_rst !== 1'b0) bad_pll++;
      if (sys_rstn === 1'b1) break;
    end
    n_total++; if (n !== 5) $display("FAIL sw_held_release_after_fall: got %0d want 5", n); else n_pass++;
    n_total++; if (bad_pll !== 0) $display("FAIL sw_outputs_during_hold: got %0d bad samples want 0", bad_pll); else n_pass++;
    n_total++; if (state !== 3'd3) $display("FAIL sw_back_to_run: got %0d want 3", state); else n_pass++;
  endtask

  task automatic test_lock_loss();
    int n;
    model_drop = 1'b1;
    tick();
    tick();
    n_total++; if (sys_rstn !== 1'b1) $display("FAIL loss_edge1_sys_rstn: got %b want 1", sys_rstn); else n_pass++;
    n_total++; if (pll_rst !== 1'b0) $display("FAIL loss_edge1_pll_rst: got %b want 0", pll_rst); else n_pass++;
    tick();
    n_total++; if (sys_rstn !== 1'b0) $display("FAIL loss_edge2_sys_rstn: got %b want 0", sys_rstn); else n_pass++;
    n_total++; if (pll_rst !== 1'b1) $display("FAIL loss_edge2_pll_rst: got %b want 1", pll_rst); else n_pass++;
    n_total++; if (lock_lost !== 1'b1) $display("FAIL loss_flag: got %b want 1", lock_lost); else n_pass++;
    n_total++; if (retry !== 8'd1) $display("FAIL loss_retry: got %0d want 1", retry); else n_pass++;
    model_drop = 1'b0;
    measure_release(n);
    n_total++; if (n !== 9) $display("FAIL loss_recovery_latency: got %0d want 9", n); else n_pass++;
    n_total++; if (lock_lost !== 1'b1) $display("FAIL loss_flag_sticky: got %b want 1", lock_lost); else n_pass++;
    n_total++; if (retry !== 8'd1) $display("FAIL loss_retry_after_recovery: got %0d want 1", retry); else n_pass++;
  endtask

  task automatic test_async_reset();
    model_drop = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state === 3'd0) break;
    end
    model_drop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state === 3'd2) break;
    end
    n_total++; if (state !== 3'd2) $display("FAIL async_reached_stable: got %0d want 2", state); else n_pass++;
    n_total++; if (lock_lost !== 1'b1) $display("FAIL async_pre_flag: got %b want 1", lock_lost); else n_pass++;
    #2;
    rstn = 1'b0;
    #1;
    n_total++; if (pll_rst !== 1'b1) $display("FAIL async_pll_rst: got %b want 1", pll_rst); else n_pass++;
    n_total++; if (sys_rstn !== 1'b0) $display("FAIL async_sys_rstn: got %b want 0", sys_rstn); else n_pass++;
    n_total++; if (lock_lost !== 1'b0) $display("FAIL async_lock_lost: got %b want 0", lock_lost); else n_pass++;
    n_total++; if (retry !== 8'd0) $display("FAIL async_retry: got %0d want 0", retry); else n_pass++;
    n_total++; if (state !== 3'd0) $display("FAIL async_state: got %0d want 0", state); else n_pass++;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_unstable();
    int n;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state === 3'd2) break;
    end
    tick();
    tick();
    model_drop = 1'b1;
    tick();
    tick();
    tick();
    n_total++; if (state !== 3'd1) $display("FAIL unstable_back_to_wait: got %0d want 1", state); else n_pass++;
    n_total++; if (sys_rstn !== 1'b0) $display("FAIL unstable_sys_rstn: got %b want 0", sys_rstn); else n_pass++;
    n_total++; if (retry !== 8'd0) $display("FAIL unstable_retry: got %0d want 0", retry); else n_pass++;
    model_drop = 1'b0;
    measure_release(n);
    n_total++; if (n !== 9) $display("FAIL unstable_fresh_release: got %0d want 9", n); else n_pass++;
    n_total++; if (retry !== 8'd0) $display("FAIL unstable_retry_final: got %0d want 0", retry); else n_pass++;
  endtask

  task automatic test_timeout();
    logic prev;
    int   nrise;
    int   last_rise;
    int   first_fall;
    int   sys_high;
    model_en = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    prev = 1'b1;
    nrise = 0;
    last_rise = 0;
    first_fall = -1;
    sys_high = 0;
    for (int e = 1; e <= 110; e++) begin
      tick();
      if (sys_rstn !== 1'b0) sys_high++;
      if (prev === 1'b1 && pll_rst === 1'b0) begin
        if (first_fall < 0) begin
          first_fall = e;
        end else begin
          n_total++; if (e - last_rise !== 4) $display("FAIL timeout_pulse_width: got %0d want 4", e - last_rise); else n_pass++;
        end
      end
      if (prev === 1'b0 && pll_rst === 1'b1) begin
        nrise++;
        last_rise = e;
        n_total++; if (e !== 36 * nrise) $display("FAIL timeout_rise_edge: got %0d want %0d", e, 36 * nrise); else n_pass++;
        n_total++; if (retry !== 8'(nrise)) $display("FAIL timeout_retry: got %0d want %0d", retry, nrise); else n_pass++;
      end
      prev = pll_rst;
    end
    n_total++; if (first_fall !== 4) $display("FAIL timeout_first_fall: got %0d want 4", first_fall); else n_pass++;
    n_total++; if (nrise !== 3) $display("FAIL timeout_num_pulses: got %0d want 3", nrise); else n_pass++;
    n_total++; if (sys_high !== 0) $display("FAIL timeout_sys_rstn_high: got %0d samples want 0", sys_high); else n_pass++;
  endtask

  task automatic test_saturate();
    logic [7:0] prev;
    int         mono_bad;
    int         saw_pulse;
    int         sys_high;
    rstn2 = 1'b1;
    prev = 8'd0;
    mono_bad = 0;
    saw_pulse = 0;
    sys_high = 0;
    for (int e = 1; e <= 800; e++) begin
      tick();
      if (retry2 < prev) mono_bad++;
      prev = retry2;
      if (sys_rstn2 !== 1'b0) sys_high++;
      if (e >= 790 && pll_rst2 === 1'b1) saw_pulse++;
      if (e == 300) begin
        n_total++; if (retry2 !== 8'd100) $display("FAIL sat_retry_mid: got %0d want 100", retry2); else n_pass++;
      end
    end
    n_total++; if (retry2 !== 8'd255) $display("FAIL sat_retry_final: got %0d want 255", retry2); else n_pass++;
    n_total++; if (mono_bad !== 0) $display("FAIL sat_no_wrap: got %0d decreases want 0", mono_bad); else n_pass++;
    n_total++; if (saw_pulse == 0) $display("FAIL sat_keeps_retrying: got %0d pulses want >0", saw_pulse); else n_pass++;
    n_total++; if (sys_high !== 0) $display("FAIL sat_sys_rstn_high: got %0d samples want 0", sys_high); else n_pass++;
    n_total++; if (lock_lost2 !== 1'b0) $display("FAIL sat_lock_lost: got %b want 0", lock_lost2); else n_pass++;
    n_total++; if (state2 > 3'd1) $display("FAIL sat_state: got %0d want 0 or 1", state2); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_powerup();
    test_sw_reset();
    test_lock_loss();
    test_async_reset();
    test_unstable();
    test_timeout();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_rst_ctrl.md
# pll_rst_ctrl

Reset sequencer on the consuming side of the system PLL. It drives the PLL's active-high reset input and watches its `locked` output. It releases the NEORV32 system reset only after lock has been continuously stable, and it re-arms the PLL on lock timeout or loss of lock. It runs on the 50 MHz board reference clock, which is free-running and independent of the PLL output.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: length of each PLL reset pulse, in clk_i cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before re-arming the PLL (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive locked cycles required before reset release (≥1).
- `SYS_HOLD_CYCLES`, 64: width of the system reset generated by a software request (≥1).

Ports:
- `clk_i`  in  1  reference clock (50 MHz).
- `rstn_i`  in  1  asynchronous, active-low reset.
- `pll_locked_i`  in  1  PLL lock flag; asynchronous to clk_i.
- `sys_rst_req_i`  in  1  system reset request, already synchronous to clk_i; level or pulse.
- `pll_rst_o`  out  1  PLL reset, active high, registered.
- `sys_rstn_o`  out  1  system reset, active low, registered. The consumer resynchronises its deassertion into the PLL clock domain.
- `lock_lost_o`  out  1  sticky flag: lock dropped while in RUN. Cleared only by rstn_i.
- `retry_cnt_o`  out  8  number of PLL re-arms caused by timeout or lock loss; saturates at 255.
- `state_o`  out  3  current FSM state, for debug.

## Operation
Lock synchroniser:
- `pll_locked_i` passes through a 2-flop synchroniser; its output is `lock_s`. The FSM uses only `lock_s`.
- Flop reset value is 0.

One shared counter `cnt`:
- Width is `$clog2` of the largest cycle parameter, plus 1.
- It clears on every state change.

States, with `state_o` encoding:
- **PLL_RST (0)**
  - Hold for `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK.
- **WAIT_LOCK (1)**
  - If `lock_s`=1, go to STABLE. The transition cycle counts as stable cycle 1.
  - Otherwise, when `cnt` = `LOCK_TIMEOUT_CYCLES`-1, go to PLL_RST and increment `retry_cnt_o`.
- **STABLE (2)**
  - If `lock_s`=0, go to WAIT_LOCK. No retry increment.
  - After `LOCK_STABLE_CYCLES` consecutive locked cycles, go to RUN.
- **RUN (3)**
  - If `lock_s`=0, go to PLL_RST, set `lock_lost_o`, and increment `retry_cnt_o`.
  - Else if `sys_rst_req_i`=1, go to HOLD.
- **HOLD (4)**
  - If `lock_s`=0 at any time, go to PLL_RST, set `lock_lost_o`, and increment `retry_cnt_o`.
  - Otherwise, after `SYS_HOLD_CYCLES` cycles, go to RUN if `sys_rst_req_i`=0. If the request is still high, stay in HOLD and restart the count.

Outputs:
- `pll_rst_o` = 1 exactly while the state register equals PLL_RST.
- `sys_rstn_o` = 1 exactly while the state register equals RUN.
- Both are registered, derived from next-state, so they switch on the same edge as the state register.

Priority:
- In RUN and HOLD, lock loss beats `sys_rst_req_i`.
- `retry_cnt_o` saturates at 255: no wrap, and the FSM keeps retrying indefinitely.

Unused encodings (5–7): go to PLL_RST on the next edge.

## Timing
Reset (`rstn_i`=0, asynchronous) values:
- state PLL_RST, `cnt`=0
- `pll_rst_o`=1, `sys_rstn_o`=0
- `lock_lost_o`=0, `retry_cnt_o`=0
- synchroniser flops 0

Latencies:
- `pll_rst_o` falls on the `PLL_RST_CYCLES`-th rising edge after `rstn_i` deasserts.
- Call the first edge that samples `pll_locked_i`=1 in WAIT_LOCK edge k. Then `lock_s` is 1 after edge k+1, STABLE is entered at edge k+2, and `sys_rstn_o` rises at edge k+1+`LOCK_STABLE_CYCLES`, provided lock is held.
- A lock drop sampled at edge j deasserts `sys_rstn_o` and asserts `pll_rst_o` at edge j+2.
- `sys_rst_req_i` high at edge j (in RUN) drops `sys_rstn_o` at edge j.

Other rules:
- A `pll_locked_i` glitch narrower than one clk_i period may be missed.
- `rstn_i` asserted mid-sequence returns all outputs to their reset values immediately (asynchronous).

## Test plan
Unless stated, use parameters `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8, `SYS_HOLD_CYCLES`=5, with a PLL model that asserts `locked` 10 cycles after `pll_rst_o` falls.

1. Power-up.
   - Release `rstn_i`.
   - Required: `pll_rst_o` falls at edge 4; `sys_rstn_o` rises exactly 9 edges after `locked` is first sampled; `retry_cnt_o`=0; `lock_lost_o`=0.
2. Lock timeout.
   - Model never locks.
   - Required: `pll_rst_o` re-pulses 4 cycles wide every 36 cycles; `retry_cnt_o` counts 1, 2, 3…; with a reduced timeout, it saturates at 255; `sys_rstn_o` stays 0.
3. Unstable lock.
   - `locked` drops after 5 cycles in STABLE.
   - Required: `state_o` returns to 1; `retry_cnt_o` is unchanged; release occurs only after 8 fresh consecutive locked cycles.
4. Lock loss in RUN.
   - Drop `locked`.
   - Required: `sys_rstn_o`=0 and `pll_rst_o`=1 two edges later; `lock_lost_o`=1 and stays set through recovery; `retry_cnt_o`=1.
5. Software reset.
   - One-cycle `sys_rst_req_i` in RUN.
   - Required: `sys_rstn_o` is low for exactly 5 cycles; `pll_rst_o` stays 0.
   - Then hold the request high for 12 cycles: `sys_rstn_o` stays low until 5 cycles after the request falls.
6. Asynchronous reset mid-STABLE.
   - Assert `rstn_i` between clock edges.
   - Required: `pll_rst_o`=1, `sys_rstn_o`=0, and flags clear without waiting for a clock edge.
